// File: rtl/traffic_pkg.sv
// Shared types and constants for the emergency request front-end.
// Lane bit indices follow the Breadboard lane bus {w1,w2,s1,s2,e1,e2,n1,n2}.
package traffic_pkg;

    localparam int NUM_LANES = 8;

    localparam int LANE_W1 = 7;
    localparam int LANE_W2 = 6;
    localparam int LANE_S1 = 5;
    localparam int LANE_S2 = 4;
    localparam int LANE_E1 = 3;
    localparam int LANE_E2 = 2;
    localparam int LANE_N1 = 1;
    localparam int LANE_N2 = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Round-robin pick: first set bit of req searching upward from ptr,
    // wrapping 7 -> 0. Returns {found, index}.
    function automatic logic [3:0] rr_pick(
        input logic [NUM_LANES-1:0] req,
        input logic [2:0]           ptr
    );
        logic [3:0] r;
        logic [2:0] idx;
        r = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (req[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_debounce.sv
// Per-lane sensor debounce: emits a one-cycle accept pulse when the sensor
// has been high for DEB_CYCLES consecutive cycles. Ports: clk, rst (async
// active-low), sense (raw level), accept_pulse (combinational, one cycle).
module lane_debounce #(
    parameter int DEB_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sense,
    output logic accept_pulse
);

    localparam logic [3:0] DEB_C  = 4'(DEB_CYCLES);
    localparam logic [3:0] LAST_C = 4'(DEB_CYCLES - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!sense) begin
            cnt_d = '0;
        end else if (cnt_q != DEB_C) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Fires only on the cycle the count reaches DEB_CYCLES; a saturated
    // counter keeps a held sensor from re-arming.
    assign accept_pulse = sense && (cnt_q == LAST_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/emergency_request_arbiter.sv
// Emergency request arbiter: debounces 8 lane sensors, queues requests and
// grants one lane at a time round-robin, with min/max hold and a cool-down gap.
// Ports: clk, rst (async active-low), emgSense[7:0] raw sensors,
// emgSignal / emgLane[7:0] registered grant, pending[7:0] queued requests.
module emergency_request_arbiter
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = 3,
    parameter int MIN_HOLD   = 4,
    parameter int MAX_HOLD   = 20,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] emgSense,
    output logic       emgSignal,
    output logic [7:0] emgLane,
    output logic [7:0] pending
);

    localparam logic [7:0] MIN_C = 8'(MIN_HOLD);
    localparam logic [7:0] MAX_C = 8'(MAX_HOLD);
    localparam logic [7:0] GAP_C = 8'(GAP_CYCLES);

    logic [NUM_LANES-1:0] accept;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk          (clk),
            .rst          (rst),
            .sense        (emgSense[i]),
            .accept_pulse (accept[i])
        );
    end

    state_e     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] win_q, win_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sig_q, sig_d;
    logic [7:0] lane_q, lane_d;
    logic [7:0] clr;
    logic [3:0] pick;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        lane_d  = lane_q;
        clr     = '0;
        pick    = rr_pick(pending_q, ptr_q);

        unique case (state_q)
            IDLE: begin
                if (pick[3]) begin
                    state_d      = GRANT;
                    win_d        = pick[2:0];
                    ptr_d        = pick[2:0] + 3'd1;
                    clr[pick[2:0]] = 1'b1;
                    cnt_d        = 8'd1;
                    sig_d        = 1'b1;
                    lane_d       = 8'd1 << pick[2:0];
                end
            end
            GRANT: begin
                if ((cnt_q >= MIN_C && !emgSense[win_q]) || cnt_q == MAX_C) begin
                    sig_d  = 1'b0;
                    lane_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sig_d   = 1'b0;
                lane_d  = '0;
            end
        endcase

        // A new accept on the grant edge survives the clear.
        pending_d = (pending_q & ~clr) | accept;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            sig_q     <= 1'b0;
            lane_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            sig_q     <= sig_d;
            lane_q    <= lane_d;
        end
    end

    assign emgSignal = sig_q;
    assign emgLane   = lane_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_emergency_request_arbiter.sv
// Self-checking bench for emergency_request_arbiter (default parameters).
// Table-driven scenarios plus hand sequences; grants scored from a queue.
module tb_emergency_request_arbiter;

    // Low cycles between back-to-back grants: GAP_CYCLES in GAP plus the
    // IDLE cycle that makes the next pick.
    localparam int GAP_LOW = 3;

    logic       clk;
    logic       rst;
    logic [7:0] emgSense;
    logic       emgSignal;
    logic [7:0] emgLane;
    logic [7:0] pending;

    emergency_request_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .emgSense  (emgSense),
        .emgSignal (emgSignal),
        .emgLane   (emgLane),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] lane;
        int         len;
        int         gap;
    } grant_t;

    grant_t exp_q[$];

    logic       mon_en = 1'b0;
    logic       in_grant = 1'b0;
    int         cur_len = 0;
    int         low_cnt = 0;
    logic [7:0] cur_lane = '0;

    always @(negedge clk) begin
        if (!mon_en || !rst) begin
            in_grant = 1'b0;
            cur_len  = 0;
            low_cnt  = 0;
        end else if (emgSignal) begin
            if (!in_grant) begin
                in_grant = 1'b1;
                cur_len  = 1;
                cur_lane = emgLane;
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", emgLane, 8'h00);
                end else begin
                    check("grant_lane", emgLane, exp_q[0].lane);
                    if (exp_q[0].gap >= 0)
                        check("grant_gap", low_cnt, exp_q[0].gap);
                end
            end else begin
                cur_len++;
                check("lane_stable", emgLane, cur_lane);
            end
        end else begin
            check("lane_zero_idle", emgLane, 8'h00);
            if (in_grant) begin
                in_grant = 1'b0;
                if (exp_q.size() > 0) begin
                    check("grant_len", cur_len, exp_q[0].len);
                    void'(exp_q.pop_front());
                end
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        emgSense = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            emgSense = 8'($urandom);
            #1;
            check("rst_sig", emgSignal, 1'b0);
            check("rst_lane", emgLane, 8'h00);
            check("rst_pend", pending, 8'h00);
        end
        emgSense = '0;
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && (exp_q.size() != 0 || in_grant); i++)
            @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] sense;
        int         high;
        logic [7:0] pend3;
        logic [7:0] lane4;
        logic [7:0] g0;
        int         l0;
        logic [7:0] g1;
        int         l1;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #400000;
        $display("FAIL watchdog: test did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [7:0] s;

        vecs[0]  = '{8'h08,  2, 8'h00, 8'h00, 8'h00,  0, 8'h00, 0};
        vecs[1]  = '{8'h08, 10, 8'h08, 8'h08, 8'h08,  7, 8'h00, 0};
        vecs[2]  = '{8'h20,  3, 8'h20, 8'h20, 8'h20,  4, 8'h00, 0};
        vecs[3]  = '{8'h01,  1, 8'h00, 8'h00, 8'h00,  0, 8'h00, 0};
        vecs[4]  = '{8'h80, 30, 8'h80, 8'h80, 8'h80, 20, 8'h00, 0};
        vecs[5]  = '{8'h20,  6, 8'h20, 8'h20, 8'h20,  4, 8'h00, 0};
        vecs[6]  = '{8'h10,  8, 8'h10, 8'h10, 8'h10,  5, 8'h00, 0};
        vecs[7]  = '{8'h04, 22, 8'h04, 8'h04, 8'h04, 19, 8'h00, 0};
        vecs[8]  = '{8'h40, 23, 8'h40, 8'h40, 8'h40, 20, 8'h00, 0};
        vecs[9]  = '{8'h06,  3, 8'h06, 8'h02, 8'h02,  4, 8'h04, 4};
        vecs[10] = '{8'h81,  5, 8'h81, 8'h01, 8'h01,  4, 8'h80, 4};

        rst      = 1'b0;
        emgSense = '0;

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            do_reset();
            if (v.g0 != 0) exp_q.push_back('{v.g0, v.l0, -1});
            if (v.g1 != 0) exp_q.push_back('{v.g1, v.l1, GAP_LOW});
            @(negedge clk);
            emgSense = v.sense;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (k == v.high) emgSense = '0;
                if (k == 3) check("pend_edge3", pending, v.pend3);
                if (k == 4) begin
                    check("lane_edge4", emgLane, v.lane4);
                    check("sig_edge4", emgSignal, v.lane4 != 0);
                end
            end
            drain();
            check("pend_final", pending, 8'h00);
        end

        // Round-robin with lane n2 re-requesting during the w1 grant.
        do_reset();
        exp_q.push_back('{8'h01, 20, -1});
        exp_q.push_back('{8'h80, 20, GAP_LOW});
        exp_q.push_back('{8'h01, 20, GAP_LOW});
        for (int j = 0; j < 90; j++) begin
            if (j < 30)       s = 8'h81;
            else if (j == 30) s = 8'h80;
            else if (j <= 80) s = 8'h81;
            else              s = 8'h00;
            emgSense = s;
            @(negedge clk);
            if (j == 3)  check("rr_first", emgLane, 8'h01);
            if (j == 26) check("rr_second", emgLane, 8'h80);
            if (j == 49) check("rr_third", emgLane, 8'h01);
            if (j == 75) check("rr_pend_empty", pending, 8'h00);
        end
        emgSense = '0;
        drain();

        // Lane e1 re-accepts on the very edge it is granted: set beats clear.
        do_reset();
        exp_q.push_back('{8'h04, 4, -1});
        exp_q.push_back('{8'h08, 4, GAP_LOW});
        exp_q.push_back('{8'h08, 4, GAP_LOW});
        for (int j = 0; j < 30; j++) begin
            s = '0;
            s[2] = (j < 3);
            s[3] = (j < 3) || (j >= 8 && j <= 11);
            emgSense = s;
            @(negedge clk);
            if (j == 10) begin
                check("setwins_pend", pending, 8'h08);
                check("setwins_lane", emgLane, 8'h08);
            end
        end
        emgSense = '0;
        drain();

        // Asynchronous reset in the middle of a grant.
        do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        emgSense = 8'h08;
        for (int j = 0; j < 6; j++) @(negedge clk);
        check("ar_granted", emgSignal, 1'b1);
        check("ar_lane", emgLane, 8'h08);
        #2 rst = 1'b0;
        #1;
        check("ar_sig_drop", emgSignal, 1'b0);
        check("ar_lane_drop", emgLane, 8'h00);
        check("ar_pend_drop", pending, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j < 2) begin
                check("ar_no_grant", emgSignal, 1'b0);
                check("ar_no_pend", pending, 8'h00);
            end
            if (j == 2) begin
                check("ar_rearm_pend", pending, 8'h08);
                check("ar_rearm_nogrant", emgSignal, 1'b0);
            end
            if (j == 3) check("ar_regrant", emgLane, 8'h08);
        end
        emgSense = '0;
        begin
            int t;
            for (t = 0; t < 30 && emgSignal; t++) @(negedge clk);
            check("ar_release", emgSignal, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
